// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset PC and presented-instruction bundle.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        exception;
   } fetch_out_t;

   // Instructions are 4-byte aligned; any set low bit is a misaligned fetch.
   function automatic logic pc_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues single-outstanding bus
// requests, buffers the returned word and presents it under a valid/stall handshake.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_exception
);

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         exc_q, exc_d;
   logic [63:0]  pend_q, pend_d;

   logic         req_c;
   logic         hold_c;
   fetch_out_t   out_s;

   // State and datapath registers, asynchronously reset to the boot PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         exc_q   <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         exc_q   <= exc_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic; request/valid depend only on state and PC, never on stall or redirect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      exc_d   = exc_q;
      pend_d  = pend_q;
      req_c   = 1'b0;
      hold_c  = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (pc_misaligned(pc_q[1:0])) begin
               exc_d   = 1'b1;
               instr_d = '0;
               state_d = HOLD;
            end else begin
               req_c = 1'b1;
               if (iresp_data_ok) begin
                  if (redirect_valid) begin
                     pc_d = redirect_pc;
                  end else begin
                     instr_d = iresp_data;
                     exc_d   = 1'b0;
                     state_d = HOLD;
                  end
               end else if (redirect_valid) begin
                  pend_d  = redirect_pc;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Old request stays on the bus until its response retires it; last redirect wins.
            req_c = 1'b1;
            if (redirect_valid) begin
               pend_d = redirect_pc;
            end
            if (iresp_data_ok) begin
               pc_d    = redirect_valid ? redirect_pc : pend_q;
               state_d = FETCH;
            end
         end
         HOLD: begin
            hold_c = 1'b1;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = FETCH;
            end else if (!stall) begin
               pc_d    = pc_q + 64'd4;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // Output view; reset gates the handshakes so they drop without waiting for a clock.
   always_comb begin
      out_s.pc        = pc_q;
      out_s.instr     = hold_c ? instr_q : '0;
      out_s.exception = hold_c & exc_q & ~reset;
   end

   assign ireq_valid    = req_c & ~reset;
   assign ireq_addr     = pc_q;
   assign out_valid     = hold_c & ~reset;
   assign out_pc        = out_s.pc;
   assign out_instr     = out_s.instr;
   assign out_exception = out_s.exception;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: feature tasks drive the bus and handshake,
// a scoreboard checks every presented instruction against expectations.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        stall;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_exception;

   int unsigned total;
   int unsigned bad;
   fetch_out_t  sb[$];

   fetch_ctrl #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_exception  (out_exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pops one expectation per new presentation (rising out_valid).
   task automatic monitor();
      logic       prev;
      fetch_out_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !prev) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected got pc=%h instr=%h exc=%b exp=none", out_pc, out_instr, out_exception);
            end else begin
               e = sb.pop_front();
               if ({out_pc, out_instr, out_exception} !== e) begin
                  bad++;
                  $display("FAIL sb_out got pc=%h instr=%h exc=%b exp pc=%h instr=%h exc=%b",
                           out_pc, out_instr, out_exception, e.pc, e.instr, e.exception);
               end
            end
         end
         prev = out_valid;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_ireq got=%b exp=0", ireq_valid); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++;
      if (out_exception !== 1'b0) begin bad++; $display("FAIL rst_exc got=%b exp=0", out_exception); end
      total++;
      if (out_pc !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL rst_pc got=%h exp=80000000", out_pc); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      @(negedge clk);
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0000}) begin
         bad++; $display("FAIL basic_req got v=%b a=%h exp v=1 a=80000000", ireq_valid, ireq_addr);
      end
      iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
      sb.push_back('{pc: 64'h8000_0000, instr: 32'h0000_0013, exception: 1'b0});
      @(negedge clk);
      iresp_data_ok = 1'b0;
      total++;
      if ({ireq_valid, out_valid} !== 2'b01) begin
         bad++; $display("FAIL basic_hold got req=%b ov=%b exp req=0 ov=1", ireq_valid, out_valid);
      end
      @(negedge clk);
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0004}) begin
         bad++; $display("FAIL basic_next got v=%b a=%h exp v=1 a=80000004", ireq_valid, ireq_addr);
      end
   endtask

   task automatic test_stall();
      iresp_data_ok = 1'b1; iresp_data = 32'h0010_0093; stall = 1'b1;
      sb.push_back('{pc: 64'h8000_0004, instr: 32'h0010_0093, exception: 1'b0});
      @(negedge clk);
      iresp_data_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({out_valid, ireq_valid, out_pc, out_instr} !== {1'b1, 1'b0, 64'h8000_0004, 32'h0010_0093}) begin
            bad++; $display("FAIL stall_stable[%0d] got ov=%b req=%b pc=%h instr=%h exp ov=1 req=0 pc=80000004 instr=00100093",
                            i, out_valid, ireq_valid, out_pc, out_instr);
         end
         if (i == 2) stall = 1'b0;
         @(negedge clk);
      end
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0008}) begin
         bad++; $display("FAIL stall_next got v=%b a=%h exp v=1 a=80000008", ireq_valid, ireq_addr);
      end
   endtask

   task automatic test_redirect_drain();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h8000_0008, 1'b0}) begin
            bad++; $display("FAIL drain_hold[%0d] got v=%b a=%h ov=%b exp v=1 a=80000008 ov=0",
                            i, ireq_valid, ireq_addr, out_valid);
         end
         if (i == 3) begin iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; end
         @(negedge clk);
      end
      iresp_data_ok = 1'b0;
      total++;
      if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h8000_1000, 1'b0}) begin
         bad++; $display("FAIL drain_resume got v=%b a=%h ov=%b exp v=1 a=80001000 ov=0", ireq_valid, ireq_addr, out_valid);
      end
   endtask

   task automatic test_two_redirects();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
      @(negedge clk);
      redirect_pc = 64'h8000_3000;
      @(negedge clk);
      redirect_valid = 1'b0;
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_1000}) begin
         bad++; $display("FAIL two_redir_old got v=%b a=%h exp v=1 a=80001000", ireq_valid, ireq_addr);
      end
      iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
      @(negedge clk);
      iresp_data_ok = 1'b0;
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_3000}) begin
         bad++; $display("FAIL two_redir_last got v=%b a=%h exp v=1 a=80003000", ireq_valid, ireq_addr);
      end
      iresp_data_ok = 1'b1; iresp_data = 32'h0000_0033;
      sb.push_back('{pc: 64'h8000_3000, instr: 32'h0000_0033, exception: 1'b0});
      @(negedge clk);
      iresp_data_ok = 1'b0;
      @(negedge clk);
      total++;
      if (ireq_addr !== 64'h8000_3004) begin
         bad++; $display("FAIL two_redir_next got a=%h exp a=80003004", ireq_addr);
      end
   endtask

   task automatic test_redirect_same_cycle();
      iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
      @(negedge clk);
      iresp_data_ok = 1'b0; redirect_valid = 1'b0;
      total++;
      if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h8000_4000, 1'b0}) begin
         bad++; $display("FAIL same_cyc got v=%b a=%h ov=%b exp v=1 a=80004000 ov=0", ireq_valid, ireq_addr, out_valid);
      end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
      @(negedge clk);
      redirect_valid = 1'b0; iresp_data_ok = 1'b1; iresp_data = 32'h3333_3333;
      @(negedge clk);
      iresp_data_ok = 1'b0;
      total++;
      if ({ireq_valid, out_valid, ireq_addr} !== {1'b0, 1'b0, 64'h8000_0102}) begin
         bad++; $display("FAIL mis_noreq got v=%b ov=%b a=%h exp v=0 ov=0 a=80000102", ireq_valid, out_valid, ireq_addr);
      end
      sb.push_back('{pc: 64'h8000_0102, instr: 32'h0, exception: 1'b1});
      @(negedge clk);
      total++;
      if ({out_valid, out_exception, out_instr, ireq_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
         bad++; $display("FAIL mis_hold got ov=%b exc=%b instr=%h req=%b exp ov=1 exc=1 instr=0 req=0",
                         out_valid, out_exception, out_instr, ireq_valid);
      end
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
      @(negedge clk);
      stall = 1'b0; redirect_valid = 1'b0;
      total++;
      if ({ireq_valid, ireq_addr, out_exception} !== {1'b1, 64'h8000_0200, 1'b0}) begin
         bad++; $display("FAIL mis_redir got v=%b a=%h exc=%b exp v=1 a=80000200 exc=0", ireq_valid, ireq_addr, out_exception);
      end
   endtask

   task automatic test_wrap();
      iresp_data_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0; iresp_data = 32'h0000_0013;
      sb.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: 32'h0000_0013, exception: 1'b0});
      @(negedge clk);
      iresp_data_ok = 1'b0;
      @(negedge clk);
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h0}) begin
         bad++; $display("FAIL wrap got v=%b a=%h exp v=1 a=0", ireq_valid, ireq_addr);
      end
   endtask

   task automatic test_reset_mid();
      iresp_data_ok = 1'b1; iresp_data = 32'h4444_4444;
      sb.push_back('{pc: 64'h0, instr: 32'h4444_4444, exception: 1'b0});
      @(negedge clk);
      iresp_data_ok = 1'b0; stall = 1'b1;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({out_valid, ireq_valid} !== 2'b00) begin
         bad++; $display("FAIL rst_hold_async got ov=%b req=%b exp ov=0 req=0", out_valid, ireq_valid);
      end
      @(negedge clk);
      stall = 1'b0;
      total++;
      if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL rst_hold_pc got=%h exp=80000000", out_pc); end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (ireq_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", ireq_valid); end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({ireq_valid, out_valid} !== 2'b00) begin
         bad++; $display("FAIL rst_req_async got req=%b ov=%b exp req=0 ov=0", ireq_valid, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0000}) begin
         bad++; $display("FAIL rst_restart got v=%b a=%h exp v=1 a=80000000", ireq_valid, ireq_addr);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; iresp_data_ok = 1'b0; iresp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_stall();
      test_redirect_drain();
      test_two_redirects();
      test_redirect_same_cycle();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
